// File: rtl/uart_start_detect_if.sv
// Signal bundle between the UART receive path and the start-bit detector.
// The receiver (master) drives the line and control inputs; the detector (slave) reports.
interface uart_start_detect_if;
  logic rx_in;
  logic baud_tick;
  logic enable;
  logic busy;
  logic sbitdet;
  logic false_start;
  logic rx_sync;
  logic det_active;

  modport master (
    output rx_in, baud_tick, enable, busy,
    input  sbitdet, false_start, rx_sync, det_active
  );

  modport slave (
    input  rx_in, baud_tick, enable, busy,
    output sbitdet, false_start, rx_sync, det_active
  );
endinterface

// File: rtl/uart_start_detect.sv
// UART start-bit detector: synchronises rx_in, finds the idle-to-start edge and
// confirms it with a 3-sample majority vote around mid-bit.
module uart_start_detect #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_start_detect_if.slave  bus
);
  localparam int CNT_W   = $clog2(OVERSAMPLE);
  localparam int HALF    = OVERSAMPLE / 2;
  localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]   C_SMP0  = CNT_W'(HALF - 2);
  localparam logic [CNT_W-1:0]   C_SMP1  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0]   C_SMP2  = CNT_W'(HALF);
  localparam logic [FLUSH_W-1:0] C_FLUSH = FLUSH_W'(SYNC_STAGES);

  typedef enum logic [1:0] {
    S_WAIT_IDLE = 2'd0,
    S_HUNT      = 2'd1,
    S_VERIFY    = 2'd2,
    S_HOLD      = 2'd3
  } state_t;

  function automatic logic f_majority_low(input logic [2:0] v);
    return (~v[0] & ~v[1]) | (~v[0] & ~v[2]) | (~v[1] & ~v[2]);
  endfunction

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rx_prev;
  logic [FLUSH_W-1:0]     r_flush_cnt;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_tick_cnt;
  logic [2:0]             r_vote;
  logic                   r_sbitdet;
  logic                   r_false_start;
  logic                   r_det_active;

  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       w_tick_cnt_nxt;
  logic [2:0]             w_vote_nxt;
  logic                   w_sbitdet_nxt;
  logic                   w_false_nxt;
  logic                   w_rx_sync;
  logic                   w_fall;
  logic                   w_primed;

  assign w_rx_sync = r_sync[SYNC_STAGES-1];
  assign w_fall    = r_rx_prev & ~w_rx_sync;
  // The reset value of the synchroniser is not a real line level; wait until rx_in has flushed through.
  assign w_primed  = (r_flush_cnt == C_FLUSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync      <= {SYNC_STAGES{1'b1}};
      r_rx_prev   <= 1'b1;
      r_flush_cnt <= {FLUSH_W{1'b0}};
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], bus.rx_in};
      r_rx_prev <= w_rx_sync;
      if (!w_primed) begin
        r_flush_cnt <= r_flush_cnt + FLUSH_W'(1);
      end else begin
        r_flush_cnt <= r_flush_cnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_WAIT_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_tick_cnt_nxt = r_tick_cnt;
    w_vote_nxt     = r_vote;
    w_sbitdet_nxt  = 1'b0;
    w_false_nxt    = 1'b0;
    if (!bus.enable) begin
      w_state_nxt    = S_WAIT_IDLE;
      w_tick_cnt_nxt = {CNT_W{1'b0}};
    end else begin
      case (r_state)
        S_WAIT_IDLE: begin
          if (w_primed && w_rx_sync) begin
            w_state_nxt = S_HUNT;
          end else begin
            w_state_nxt = S_WAIT_IDLE;
          end
        end
        S_HUNT: begin
          if (w_fall && !bus.busy) begin
            w_state_nxt    = S_VERIFY;
            w_tick_cnt_nxt = {CNT_W{1'b0}};
            w_vote_nxt     = 3'b000;
          end else begin
            w_state_nxt = S_HUNT;
          end
        end
        S_VERIFY: begin
          if (bus.baud_tick) begin
            w_tick_cnt_nxt = r_tick_cnt + CNT_W'(1);
            if (r_tick_cnt == C_SMP0) begin
              w_vote_nxt[0] = w_rx_sync;
            end else if (r_tick_cnt == C_SMP1) begin
              w_vote_nxt[1] = w_rx_sync;
            end else if (r_tick_cnt == C_SMP2) begin
              // Last sample joins the vote directly so the verdict lands one clk after it.
              w_vote_nxt[2]  = w_rx_sync;
              w_tick_cnt_nxt = {CNT_W{1'b0}};
              if (f_majority_low({w_rx_sync, r_vote[1:0]})) begin
                w_sbitdet_nxt = 1'b1;
                w_state_nxt   = S_HOLD;
              end else begin
                w_false_nxt = 1'b1;
                w_state_nxt = S_HUNT;
              end
            end else begin
              w_vote_nxt = r_vote;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt;
          end
        end
        S_HOLD: begin
          if (!bus.busy && w_rx_sync) begin
            w_state_nxt = S_HUNT;
          end else begin
            w_state_nxt = S_HOLD;
          end
        end
        default: begin
          w_state_nxt = S_WAIT_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt    <= {CNT_W{1'b0}};
      r_vote        <= 3'b000;
      r_sbitdet     <= 1'b0;
      r_false_start <= 1'b0;
      r_det_active  <= 1'b0;
    end else begin
      r_tick_cnt    <= w_tick_cnt_nxt;
      r_vote        <= w_vote_nxt;
      r_sbitdet     <= w_sbitdet_nxt;
      r_false_start <= w_false_nxt;
      r_det_active  <= (w_state_nxt == S_VERIFY);
    end
  end

  assign bus.sbitdet     = r_sbitdet;
  assign bus.false_start = r_false_start;
  assign bus.rx_sync     = w_rx_sync;
  assign bus.det_active  = r_det_active;
endmodule

// File: tb/tb_uart_start_detect.sv
// Directed bench for uart_start_detect: a table of start-bit scenarios plus
// hand-written break, abort and asynchronous-reset sequences.
module tb_uart_start_detect;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  uart_start_detect_if ifc ();

  uart_start_detect #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    low_len;
    int    spike_s;
    int    spike_l;
    int    busy;
    int    en_off;
    int    exp_sbit;
    int    exp_false;
    int    exp_sbit_j;
    int    exp_det;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mk(string n, int ll, int ss, int sl, int b, int eo,
                              int es, int ef, int ej, int ed);
    vec_t v;
    v.name = n; v.low_len = ll; v.spike_s = ss; v.spike_l = sl; v.busy = b;
    v.en_off = eo; v.exp_sbit = es; v.exp_false = ef; v.exp_sbit_j = ej; v.exp_det = ed;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ifc.rx_in = 1'b1; ifc.baud_tick = 1'b0; ifc.enable = 1'b1; ifc.busy = 1'b0;
    end
  endtask

  // Falling edge driven at iteration 0; ticks reach the DUT on clk 4, 8, 12, ...
  task automatic run_window(input vec_t v);
    int sb, fs, det, both, sbj, rx1, rx2;
    logic r;
    sb = 0; fs = 0; det = 0; both = 0; sbj = -1; rx1 = -1; rx2 = -1;
    idle();
    for (int j = 0; j < 44; j++) begin
      @(negedge clk);
      if (ifc.sbitdet) begin
        sb++;
        if (sbj < 0) sbj = j;
      end
      if (ifc.false_start) fs++;
      if (ifc.det_active) det++;
      if (ifc.sbitdet && ifc.false_start) both++;
      if (j == 1) rx1 = int'(ifc.rx_sync);
      if (j == 2) rx2 = int'(ifc.rx_sync);
      r = (j < v.low_len) ? 1'b0 : 1'b1;
      if (j >= v.spike_s && j < v.spike_s + v.spike_l) r = 1'b1;
      ifc.rx_in     = r;
      ifc.baud_tick = (j % 4 == 3);
      ifc.enable    = (v.en_off < 0 || j < v.en_off);
      ifc.busy      = (v.busy != 0);
    end
    check({v.name, "/sbit_cnt"}, sb, v.exp_sbit);
    check({v.name, "/false_cnt"}, fs, v.exp_false);
    check({v.name, "/det_cycles"}, det, v.exp_det);
    check({v.name, "/both_high"}, both, 0);
    check({v.name, "/rx_sync_j1"}, rx1, 1);
    check({v.name, "/rx_sync_j2"}, rx2, 0);
    if (v.exp_sbit > 0) check({v.name, "/sbit_cycle"}, sbj, v.exp_sbit_j);
  endtask

  initial begin
    int sb, fs, det;
    n_checks = 0;
    n_errors = 0;
    //                name         low  sps spl busy enoff sbit false sbj det
    tbl[0] = mk("clean",       44, -1, 0, 0, -1, 1, 0, 36, 33);
    tbl[1] = mk("glitch",      12, -1, 0, 0, -1, 0, 1,  0, 33);
    tbl[2] = mk("recover",     44, -1, 0, 0, -1, 1, 0, 36, 33);
    tbl[3] = mk("spike_mid",   44, 27, 4, 0, -1, 1, 0, 36, 33);
    tbl[4] = mk("spike_two",   44, 23, 8, 0, -1, 0, 1,  0, 33);
    tbl[5] = mk("late_rise",   30, -1, 0, 0, -1, 1, 0, 36, 33);
    tbl[6] = mk("busy_edge",   44, -1, 0, 1, -1, 0, 0,  0,  0);
    tbl[7] = mk("after_busy",  44, -1, 0, 0, -1, 1, 0, 36, 33);
    tbl[8] = mk("en_abort",    44, -1, 0, 0, 19, 0, 0,  0, 17);
    tbl[9] = mk("after_abort", 44, -1, 0, 0, -1, 1, 0, 36, 33);

    // Reset with the line held low (break).
    rst_n = 1'b0;
    ifc.rx_in = 1'b0; ifc.baud_tick = 1'b0; ifc.enable = 1'b1; ifc.busy = 1'b0;
    repeat (3) @(negedge clk);
    check("reset/rx_sync", int'(ifc.rx_sync), 1);
    check("reset/sbitdet", int'(ifc.sbitdet), 0);
    check("reset/false_start", int'(ifc.false_start), 0);
    check("reset/det_active", int'(ifc.det_active), 0);
    rst_n = 1'b1;
    sb = 0; fs = 0; det = 0;
    for (int j = 0; j < 200; j++) begin
      @(negedge clk);
      if (ifc.sbitdet) sb++;
      if (ifc.false_start) fs++;
      if (ifc.det_active) det++;
      ifc.rx_in = 1'b0;
      ifc.baud_tick = (j % 4 == 3);
    end
    check("break/sbit_cnt", sb, 0);
    check("break/false_cnt", fs, 0);
    check("break/det_cycles", det, 0);

    // Line returns high, then the table's first entry is the second falling edge.
    for (int i = 0; i < 10; i++) run_window(tbl[i]);

    // Asynchronous reset in the middle of VERIFY.
    idle();
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      ifc.rx_in = 1'b0;
      ifc.baud_tick = (j % 4 == 3);
    end
    @(negedge clk);
    check("arst/det_before", int'(ifc.det_active), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst/det_active", int'(ifc.det_active), 0);
    check("arst/sbitdet", int'(ifc.sbitdet), 0);
    check("arst/false_start", int'(ifc.false_start), 0);
    check("arst/rx_sync", int'(ifc.rx_sync), 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_window(tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
